// File: rtl/compress_axis_packer_if.sv
// Bus bundle for the packer: compressed-word input with backpressure, and
// the 32-bit AXI4-Stream output toward the DMA.
interface compress_axis_packer_if;
  logic [14:0] odata;
  logic        o_valid;
  logic        end_flag;
  logic        out_stop;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    input  odata, o_valid, end_flag, m_axis_tready,
    output out_stop, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output odata, o_valid, end_flag, m_axis_tready,
    input  out_stop, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/compress_axis_packer.sv
// Packs 15-bit compressed words two per 32-bit AXI4-Stream beat via a word FIFO.
// Optional macro PACK_WORD_COUNT_EN adds the word_cnt output (accepted-word counter).
module compress_axis_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 2,
  parameter int CNT_WIDTH  = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  compress_axis_packer_if.master bus,
  output logic                   done
`ifdef PACK_WORD_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   word_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(FIFO_DEPTH - AF_MARGIN);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      AF_MARGIN < 1 || AF_MARGIN > FIFO_DEPTH - 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("compress_axis_packer: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [14:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [14:0]     r_lo_q;
  logic            r_lo_v;
  logic [31:0]     r_pend_q;
  logic            r_pend_v;
  logic [31:0]     r_tdata;
  logic            r_tvalid, r_tlast, r_out_stop, r_any, r_last_sent;
  logic            w_clear, w_flush, w_push, w_wr, w_empty, w_full, w_pop;
  logic            w_out_free, w_more, w_final, w_pend_go, w_lo_fin, w_zero_fin;
  logic [14:0]     w_head;

  assign w_clear    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_flush    = (r_state == S_FLUSH);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_FULL);
  assign w_push     = bus.o_valid && !r_out_stop && (r_state == S_RUN);
  assign w_wr       = w_push && !w_full;
  assign w_head     = r_mem[r_rptr];
  assign w_out_free = !r_tvalid || bus.m_axis_tready;

  // A completed pair is held back until another word is known to follow, or
  // FLUSH proves nothing follows; only then can its tlast be decided.
  assign w_more     = !w_empty || r_lo_v;
  assign w_final    = w_flush && !w_more;
  assign w_pend_go  = r_pend_v && w_out_free && (w_more || w_flush);
  assign w_lo_fin   = w_flush && w_empty && r_lo_v && !r_pend_v && w_out_free;
  assign w_zero_fin = w_flush && !r_any && !r_last_sent && w_out_free;
  assign w_pop      = !w_empty && (!r_lo_v || !r_pend_v || w_pend_go);

  always_comb begin
    w_count_nxt = r_count;
    if (w_clear)
      w_count_nxt = '0;
    else if (w_wr && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (bus.end_flag) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_tvalid && r_tlast && bus.m_axis_tready) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_out_stop <= 1'b0;
    else if (w_state_nxt == S_RUN || w_state_nxt == S_FLUSH)
      r_out_stop <= (w_count_nxt >= C_AF);
    else
      r_out_stop <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.odata;
  end

  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_lo_q      <= '0;
      r_lo_v      <= 1'b0;
      r_pend_q    <= '0;
      r_pend_v    <= 1'b0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_any       <= 1'b0;
      r_last_sent <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
        r_any  <= 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;

      if (w_pop) begin
        if (!r_lo_v) begin
          r_lo_q <= w_head;
          r_lo_v <= 1'b1;
        end else begin
          r_lo_v <= 1'b0;
        end
      end else if (w_lo_fin) begin
        r_lo_v <= 1'b0;
      end

      if (w_pop && r_lo_v) begin
        r_pend_q <= {1'b0, w_head, 1'b0, r_lo_q};
        r_pend_v <= 1'b1;
      end else if (w_pend_go) begin
        r_pend_v <= 1'b0;
      end

      if (w_out_free) begin
        if (w_pend_go) begin
          r_tdata     <= r_pend_q;
          r_tvalid    <= 1'b1;
          r_tlast     <= w_final;
          r_last_sent <= r_last_sent | w_final;
        end else if (w_lo_fin) begin
          r_tdata     <= {17'b0, r_lo_q};
          r_tvalid    <= 1'b1;
          r_tlast     <= 1'b1;
          r_last_sent <= 1'b1;
        end else if (w_zero_fin) begin
          r_tdata     <= '0;
          r_tvalid    <= 1'b1;
          r_tlast     <= 1'b1;
          r_last_sent <= 1'b1;
        end else begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      end
    end
  end

`ifdef PACK_WORD_COUNT_EN
  logic [CNT_WIDTH-1:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst || w_clear)
      r_word_cnt <= '0;
    else if (w_push && r_word_cnt != '1)
      r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
  end

  assign word_cnt = r_word_cnt;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full));

  assign bus.out_stop      = r_out_stop;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign done              = (r_state == S_DONE);

endmodule

// File: tb/tb_compress_axis_packer.sv
// Randomized self-checking bench: words are streamed per image and every
// handshaked beat is compared against a beat list built from the word list.
module tb_compress_axis_packer;
  logic clk, rst, start, done;
`ifdef PACK_WORD_COUNT_EN
  logic [12:0] word_cnt;
`endif

  compress_axis_packer_if bus();

  compress_axis_packer #(
    .FIFO_DEPTH(16),
    .AF_MARGIN (2),
    .CNT_WIDTH (13)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus),
    .done (done)
`ifdef PACK_WORD_COUNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [14:0] imgWords[$];
  logic [32:0] expBeats[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beats: consecutive word pairs, older word in the low half; an odd
  // trailing word sits alone; an empty image is a single zero beat; tlast on the final one.
  function automatic void buildModel();
    int n;
    n = imgWords.size();
    expBeats.delete();
    if (n == 0) begin
      expBeats.push_back({1'b1, 32'h0});
    end else begin
      for (int i = 0; i < n; i += 2) begin
        if (i + 1 < n) expBeats.push_back({1'b0, 1'b0, imgWords[i+1], 1'b0, imgWords[i]});
        else           expBeats.push_back({1'b0, 17'b0, imgWords[i]});
      end
      expBeats[expBeats.size()-1][32] = 1'b1;
    end
  endfunction

  task automatic applyReset();
    rst = 1'b0;
    start = 1'b0;
    bus.o_valid = 1'b0;
    bus.odata = '0;
    bus.end_flag = 1'b0;
    bus.m_axis_tready = 1'b0;
    @(negedge clk);
    checkOutput("rstOutStop", 64'(bus.out_stop), 64'd0);
    checkOutput("rstTvalid", 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput("rstTdata", 64'(bus.m_axis_tdata), 64'd0);
    checkOutput("rstTlast", 64'(bus.m_axis_tlast), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
`ifdef PACK_WORD_COUNT_EN
    checkOutput("rstWordCnt", 64'(word_cnt), 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int readyPct, input int stallCycles,
                               input bit abortInFlush, input bit injectStart);
    int nWords, sendIdx, beatIdx, lastCnt, cyc, flushCyc, budget;
    bit prevStall;
    logic [31:0] prevData;
    logic prevLast;
    nWords = imgWords.size();
    sendIdx = 0; beatIdx = 0; lastCnt = 0; cyc = 0; flushCyc = 0;
    budget = nWords * 16 + 200;
    prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
    buildModel();
    @(negedge clk);
    start = 1'b1;
    bus.end_flag = 1'b0;
    bus.o_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < budget) begin
      if (prevStall)
        checkOutput("stableBeat", 64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}),
                    64'({1'b1, prevLast, prevData}));
      if (done) break;
      if (abortInFlush || cyc < stallCycles) bus.m_axis_tready = 1'b0;
      else bus.m_axis_tready = ($urandom_range(0, 99) < readyPct);
      start = injectStart && (cyc == 40);
      if (sendIdx < nWords) begin
        bus.o_valid = 1'b1;
        bus.odata = imgWords[sendIdx];
      end else begin
        bus.o_valid = 1'b0;
        bus.odata = 15'($urandom_range(0, 32767));
        bus.end_flag = 1'b1;
        flushCyc++;
      end
      if (bus.o_valid && !bus.out_stop) sendIdx++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (beatIdx < expBeats.size())
          checkOutput($sformatf("beat%0d", beatIdx), 64'({bus.m_axis_tlast, bus.m_axis_tdata}),
                      64'(expBeats[beatIdx]));
        else
          checkOutput("extraBeat", 64'(beatIdx + 1), 64'(expBeats.size()));
        if (bus.m_axis_tlast) lastCnt++;
        beatIdx++;
      end
      prevStall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prevData = bus.m_axis_tdata;
      prevLast = bus.m_axis_tlast;
      if (stallCycles > 0 && cyc == stallCycles - 1) begin
        checkOutput("stallOutStop", 64'(bus.out_stop), 64'd1);
        checkOutput("stallAccepted", 64'(sendIdx >= 14 && sendIdx < 20), 64'd1);
      end
      if (abortInFlush && flushCyc == 6) begin
        checkOutput("abortTvalid", 64'(bus.m_axis_tvalid), 64'd1);
        applyReset();
        return;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("done", 64'(done), 64'd1);
    checkOutput("doneOutStop", 64'(bus.out_stop), 64'd1);
    checkOutput("acceptCount", 64'(sendIdx), 64'(nWords));
    checkOutput("beatCount", 64'(beatIdx), 64'(expBeats.size()));
    checkOutput("tlastCount", 64'(lastCnt), 64'd1);
`ifdef PACK_WORD_COUNT_EN
    checkOutput("wordCnt", 64'(word_cnt), 64'(nWords > 8191 ? 8191 : nWords));
`endif
  endtask

  initial begin
    rst = 1'b0;
    applyReset();

    imgWords = '{15'h0001, 15'h7FFF, 15'h1234, 15'h0ABC};
    applyStimulus(100, 0, 1'b0, 1'b0);

    imgWords = '{15'h0011, 15'h0022, 15'h0033};
    applyStimulus(100, 0, 1'b0, 1'b0);

    imgWords.delete();
    applyStimulus(100, 0, 1'b0, 1'b0);

    imgWords.delete();
    for (int i = 0; i < 20; i++) imgWords.push_back(15'($urandom_range(0, 32767)));
    applyStimulus(100, 40, 1'b0, 1'b0);

    imgWords.delete();
    for (int i = 0; i < 4096; i++) imgWords.push_back(15'($urandom_range(0, 32767)));
    applyStimulus(50, 0, 1'b0, 1'b1);

    imgWords.delete();
    for (int i = 0; i < 5; i++) imgWords.push_back(15'($urandom_range(0, 32767)));
    applyStimulus(100, 0, 1'b1, 1'b0);

    imgWords = '{15'h2A5A, 15'h15A5};
    applyStimulus(100, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
